// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: FSM states, coin values,
// credit ceiling and a saturating credit adder.
// Ports: none (package).
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    CHECK   = 3'd2,
    VEND    = 3'd3,
    CHANGE  = 3'd4
  } state_t;

  localparam logic [7:0] COIN5      = 8'd5;
  localparam logic [7:0] COIN10     = 8'd10;
  localparam logic [7:0] COIN25     = 8'd25;
  localparam logic [7:0] CREDIT_MAX = 8'd255;

  // Add a coin to the credit, clamping at CREDIT_MAX instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/vend_if.sv
// Handshake/status bundle between the vending controller and its environment.
// master: drives item select, price, coin and request pulses; observes status.
// slave:  the controller; consumes pulses, drives credit and one-cycle strobes.
interface vend_if;
  logic [2:0] sel;
  logic [7:0] price;
  logic       c5;
  logic       c10;
  logic       c25;
  logic       buy;
  logic       cancel;
  logic [7:0] credit;
  logic       dispense;
  logic [2:0] item_out;
  logic [7:0] change;
  logic       change_valid;
  logic       shortfall;
  logic       coin_reject;

  modport master (
    output sel, price, c5, c10, c25, buy, cancel,
    input  credit, dispense, item_out, change, change_valid, shortfall, coin_reject
  );

  modport slave (
    input  sel, price, c5, c10, c25, buy, cancel,
    output credit, dispense, item_out, change, change_valid, shortfall, coin_reject
  );
endinterface

// File: rtl/credit_acc.sv
// Credit accumulator: coin priority (25 > 10 > 5), saturating add, subtract, clear.
// Latency: credit updates on the edge the command is seen; no backpressure.
// Ports: clk, rst_n, coin pulses, add/sub/clr commands, sub_val, credit, any_coin, multi_coin.
module credit_acc
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c5,
  input  logic       c10,
  input  logic       c25,
  input  logic       add,
  input  logic       sub,
  input  logic       clr,
  input  logic [7:0] sub_val,
  output logic [7:0] credit,
  output logic       any_coin,
  output logic       multi_coin
);

  logic [7:0] coin_val;

  always_comb begin
    coin_val = 8'd0;
    if (c25)      coin_val = COIN25;
    else if (c10) coin_val = COIN10;
    else if (c5)  coin_val = COIN5;
  end

  assign any_coin   = c5 | c10 | c25;
  assign multi_coin = (c5 & c10) | (c5 & c25) | (c10 & c25);

  // Clear wins over subtract wins over add; the FSM never asks for two at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= 8'd0;
    end else if (clr) begin
      credit <= 8'd0;
    end else if (sub) begin
      credit <= (credit >= sub_val) ? (credit - sub_val) : 8'd0;
    end else if (add) begin
      credit <= sat_add(credit, coin_val);
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: collects coins, checks price, vends, then returns change.
// Latency: Buy at edge n -> dispense after n+2 -> change_valid after n+3.
// Backpressure: none; all inputs are single-cycle pulses, all outputs registered.
// Ports: clk, rst_n, bus (vend_if.slave).
module vend_ctrl
  import vend_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  vend_if.slave  bus
);

  state_t     state, state_n;
  logic [2:0] sel_reg, sel_reg_n;
  logic [7:0] price_reg, price_reg_n;
  logic [7:0] credit_q;
  logic       any_coin, multi_coin;
  logic       acc_add, acc_sub, acc_clr;
  logic       dispense_n, change_valid_n, shortfall_n, coin_reject_n;
  logic [2:0] item_out_n;
  logic [7:0] change_n;

  credit_acc u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .c5         (bus.c5),
    .c10        (bus.c10),
    .c25        (bus.c25),
    .add        (acc_add),
    .sub        (acc_sub),
    .clr        (acc_clr),
    .sub_val    (price_reg),
    .credit     (credit_q),
    .any_coin   (any_coin),
    .multi_coin (multi_coin)
  );

  assign bus.credit = credit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      sel_reg          <= 3'd0;
      price_reg        <= 8'd0;
      bus.dispense     <= 1'b0;
      bus.item_out     <= 3'd0;
      bus.change       <= 8'd0;
      bus.change_valid <= 1'b0;
      bus.shortfall    <= 1'b0;
      bus.coin_reject  <= 1'b0;
    end else begin
      state            <= state_n;
      sel_reg          <= sel_reg_n;
      price_reg        <= price_reg_n;
      bus.dispense     <= dispense_n;
      bus.item_out     <= item_out_n;
      bus.change       <= change_n;
      bus.change_valid <= change_valid_n;
      bus.shortfall    <= shortfall_n;
      bus.coin_reject  <= coin_reject_n;
    end
  end

  always_comb begin
    state_n        = state;
    sel_reg_n      = sel_reg;
    price_reg_n    = price_reg;
    item_out_n     = bus.item_out;
    change_n       = bus.change;
    dispense_n     = 1'b0;
    change_valid_n = 1'b0;
    shortfall_n    = 1'b0;
    coin_reject_n  = 1'b0;
    acc_add        = 1'b0;
    acc_sub        = 1'b0;
    acc_clr        = 1'b0;

    case (state)
      IDLE: begin
        // Buy/Cancel are meaningless with no session open.
        acc_add       = any_coin;
        coin_reject_n = multi_coin;
        if (any_coin) state_n = COLLECT;
      end
      COLLECT: begin
        // A coin arriving with Buy/Cancel is credited on the same edge.
        acc_add       = any_coin;
        coin_reject_n = multi_coin;
        if (bus.cancel) begin
          state_n = CHANGE;
        end else if (bus.buy) begin
          sel_reg_n = bus.sel;
          state_n   = CHECK;
        end
      end
      CHECK: begin
        // Keep the sampled price so VEND subtracts what was checked.
        coin_reject_n = any_coin;
        price_reg_n   = bus.price;
        if (bus.price != 8'd0 && credit_q >= bus.price) begin
          state_n = VEND;
        end else begin
          shortfall_n = 1'b1;
          state_n     = COLLECT;
        end
      end
      VEND: begin
        coin_reject_n = any_coin;
        dispense_n    = 1'b1;
        item_out_n    = sel_reg;
        acc_sub       = 1'b1;
        state_n       = CHANGE;
      end
      CHANGE: begin
        coin_reject_n  = any_coin;
        change_valid_n = 1'b1;
        change_n       = credit_q;
        acc_clr        = 1'b1;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: reset values, a directed vector table,
// hand-written multi-cycle sequences and a randomized run against a queue-based model.
module tb_vend_ctrl;
  import vend_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vend_if bus();
  vend_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] price_tab [8] = '{8'd0, 8'd20, 8'd35, 8'd45, 8'd60, 8'd75, 8'd100, 8'd150};

  typedef struct {
    logic [4:0] in;     // {c5, c10, c25, buy, cancel}
    int         sel;
    int         credit;
    logic [3:0] st;     // {dispense, change_valid, shortfall, coin_reject}
    int         item;
    int         change;
  } vec_t;

  vec_t tab[$];

  localparam int K_CHECK  = 0;
  localparam int K_VEND   = 1;
  localparam int K_REFUND = 2;
  typedef struct { int kind; int sel; int price; } op_t;

  op_t q[$];
  int  m_credit;
  bit  m_collect;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c5, input logic c10, input logic c25,
                       input logic buy, input logic cancel, input int sel);
    bus.c5     = c5;
    bus.c10    = c10;
    bus.c25    = c25;
    bus.buy    = buy;
    bus.cancel = cancel;
    bus.sel    = sel[2:0];
    bus.price  = price_tab[sel[2:0]];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [4:0] in, input int sel, input int credit,
                              input logic [3:0] st, input int item, input int change);
    vec_t v;
    v.in = in; v.sel = sel; v.credit = credit; v.st = st; v.item = item; v.change = change;
    return v;
  endfunction

  // Expected outputs for one edge, derived from the vending rules: a session is
  // either open for coins, or working through a queue of pending actions.
  task automatic model(input logic c5, input logic c10, input logic c25,
                       input logic buy, input logic cancel, input int sel, input int price,
                       output int e_disp, output int e_cv, output int e_short,
                       output int e_rej, output int e_item, output int e_change);
    int  ncoin, cval;
    bit  was;
    op_t op;
    e_disp = 0; e_cv = 0; e_short = 0; e_rej = 0; e_item = 0; e_change = 0;
    ncoin = int'(c5) + int'(c10) + int'(c25);
    cval  = c25 ? 25 : (c10 ? 10 : (c5 ? 5 : 0));
    if (q.size() > 0) begin
      op    = q.pop_front();
      e_rej = (ncoin > 0);
      if (op.kind == K_CHECK) begin
        if (price != 0 && m_credit >= price) begin
          q.push_back('{K_VEND, op.sel, price});
          q.push_back('{K_REFUND, 0, 0});
        end else begin
          e_short = 1;
        end
      end else if (op.kind == K_VEND) begin
        e_disp   = 1;
        e_item   = op.sel;
        m_credit = (m_credit >= op.price) ? m_credit - op.price : 0;
      end else begin
        e_cv      = 1;
        e_change  = m_credit;
        m_credit  = 0;
        m_collect = 0;
      end
    end else begin
      was = m_collect;
      if (ncoin > 0) begin
        m_credit  = (m_credit + cval > 255) ? 255 : m_credit + cval;
        e_rej     = (ncoin > 1);
        m_collect = 1;
      end
      if (was) begin
        if (cancel)   q.push_back('{K_REFUND, 0, 0});
        else if (buy) q.push_back('{K_CHECK, sel, 0});
      end
    end
  endtask

  initial begin
    int e_disp, e_cv, e_short, e_rej, e_item, e_change;
    logic r5, r10, r25, rb, rc;
    int   rs;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_credit", bus.credit, 0);
    chk("rst_dispense", bus.dispense, 0);
    chk("rst_change_valid", bus.change_valid, 0);
    chk("rst_shortfall", bus.shortfall, 0);
    chk("rst_coin_reject", bus.coin_reject, 0);
    chk("rst_item_out", bus.item_out, 0);
    chk("rst_change", bus.change, 0);
    @(negedge clk) rst_n = 1'b1;

    // ---------------- directed vector table ----------------
    //              c5 c10 c25 buy cancel
    tab.push_back(mk(5'b00000, 0,  0, 4'b0000, 0,  0));
    // normal vend: 25+25, buy item 3 at 45
    tab.push_back(mk(5'b00100, 0, 25, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00100, 0, 50, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00010, 3, 50, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00000, 3, 50, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00000, 3,  5, 4'b1000, 3,  0));
    tab.push_back(mk(5'b00000, 3,  0, 4'b0100, 0,  5));
    tab.push_back(mk(5'b00000, 0,  0, 4'b0000, 0,  0));
    // insufficient credit, then refund
    tab.push_back(mk(5'b01000, 0, 10, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00010, 3, 10, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00000, 3, 10, 4'b0010, 0,  0));
    tab.push_back(mk(5'b00000, 0, 10, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00001, 0, 10, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00000, 0,  0, 4'b0100, 0, 10));
    // refund of 25+10
    tab.push_back(mk(5'b00100, 0, 25, 4'b0000, 0,  0));
    tab.push_back(mk(5'b01000, 0, 35, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00001, 0, 35, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00000, 0,  0, 4'b0100, 0, 35));
    // coin conflict, coins during CHECK and VEND
    tab.push_back(mk(5'b10100, 0, 25, 4'b0001, 0,  0));
    tab.push_back(mk(5'b00010, 1, 25, 4'b0000, 0,  0));
    tab.push_back(mk(5'b01000, 1, 25, 4'b0001, 0,  0));
    tab.push_back(mk(5'b10000, 1,  5, 4'b1001, 1,  0));
    tab.push_back(mk(5'b00000, 1,  0, 4'b0100, 0,  5));
    // buy + cancel together: refund wins
    tab.push_back(mk(5'b01000, 0, 10, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00011, 1, 10, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00000, 1,  0, 4'b0100, 0, 10));
    // zero price gives shortfall
    tab.push_back(mk(5'b10000, 0,  5, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00010, 0,  5, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00000, 0,  5, 4'b0010, 0,  0));
    tab.push_back(mk(5'b00001, 0,  5, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00000, 0,  0, 4'b0100, 0,  5));
    // buy in IDLE ignored
    tab.push_back(mk(5'b00010, 1,  0, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00000, 1,  0, 4'b0000, 0,  0));
    // exact price: zero change still strobes
    tab.push_back(mk(5'b01000, 0, 10, 4'b0000, 0,  0));
    tab.push_back(mk(5'b01000, 0, 20, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00010, 1, 20, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00000, 1, 20, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00000, 1,  0, 4'b1000, 1,  0));
    tab.push_back(mk(5'b00000, 1,  0, 4'b0100, 0,  0));
    // coin with buy is credited before the check
    tab.push_back(mk(5'b10000, 0,  5, 4'b0000, 0,  0));
    tab.push_back(mk(5'b01010, 1, 15, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00000, 1, 15, 4'b0010, 0,  0));
    tab.push_back(mk(5'b00001, 0, 15, 4'b0000, 0,  0));
    tab.push_back(mk(5'b00000, 0,  0, 4'b0100, 0, 15));

    foreach (tab[i]) begin
      drive(tab[i].in[4], tab[i].in[3], tab[i].in[2], tab[i].in[1], tab[i].in[0], tab[i].sel);
      tick();
      chk($sformatf("vec%0d_credit", i), bus.credit, tab[i].credit);
      chk($sformatf("vec%0d_dispense", i), bus.dispense, tab[i].st[3]);
      chk($sformatf("vec%0d_change_valid", i), bus.change_valid, tab[i].st[2]);
      chk($sformatf("vec%0d_shortfall", i), bus.shortfall, tab[i].st[1]);
      chk($sformatf("vec%0d_coin_reject", i), bus.coin_reject, tab[i].st[0]);
      if (tab[i].st[3]) chk($sformatf("vec%0d_item_out", i), bus.item_out, tab[i].item);
      if (tab[i].st[2]) chk($sformatf("vec%0d_change", i), bus.change, tab[i].change);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // ---------------- saturation: eleven quarters ----------------
    for (int k = 0; k < 11; k++) begin
      drive(0, 0, 1, 0, 0, 0);
      tick();
      if (k == 9) chk("sat_credit_250", bus.credit, 250);
    end
    chk("sat_credit_255", bus.credit, 255);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    chk("sat_hold_255", bus.credit, 255);
    drive(0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("sat_refund_cv", bus.change_valid, 1);
    chk("sat_refund_change", bus.change, 255);

    // ---------------- reset while in VEND ----------------
    drive(0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 3); tick();
    drive(0, 0, 0, 0, 0, 3); tick();   // CHECK passed; now in VEND
    chk("rv_credit_before", bus.credit, 50);
    #2 rst_n = 1'b0;
    #1;
    chk("rv_credit_async", bus.credit, 0);
    chk("rv_dispense_async", bus.dispense, 0);
    chk("rv_cv_async", bus.change_valid, 0);
    chk("rv_change_async", bus.change, 0);
    chk("rv_item_async", bus.item_out, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rv_post_dispense", bus.dispense, 0);
      chk("rv_post_cv", bus.change_valid, 0);
      chk("rv_post_credit", bus.credit, 0);
    end

    // ---------------- randomized run against the model ----------------
    do_reset();
    m_credit  = 0;
    m_collect = 0;
    q.delete();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r5  = ($urandom_range(0, 5) == 0);
      r10 = ($urandom_range(0, 5) == 0);
      r25 = ($urandom_range(0, 4) == 0);
      rb  = ($urandom_range(0, 5) == 0);
      rc  = ($urandom_range(0, 11) == 0);
      rs  = $urandom_range(0, 7);
      drive(r5, r10, r25, rb, rc, rs);
      tick();
      model(r5, r10, r25, rb, rc, rs, int'(price_tab[rs]),
            e_disp, e_cv, e_short, e_rej, e_item, e_change);
      chk("rnd_credit", bus.credit, m_credit);
      chk("rnd_dispense", bus.dispense, e_disp);
      chk("rnd_change_valid", bus.change_valid, e_cv);
      chk("rnd_shortfall", bus.shortfall, e_short);
      chk("rnd_coin_reject", bus.coin_reject, e_rej);
      if (e_disp != 0) chk("rnd_item_out", bus.item_out, e_item);
      if (e_cv != 0)   chk("rnd_change", bus.change, e_change);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Clock  input  1  rising-edge system clock.
REQ-003 Resetn  input  1  asynchronous active-low reset.
REQ-004 Sel  input  3  item select; also drives the price mux select.
REQ-005 Price  input  8  price of the selected item from the price mux, in cents.
REQ-006 C5, C10, C25  input  1 each  single-cycle coin pulses worth 5, 10 and 25 cents.
REQ-007 Buy, Cancel  input  1 each  single-cycle request pulses.
REQ-008 Credit  output  8  current accumulated credit.
REQ-009 Dispense  output  1  one-cycle vend strobe.
REQ-010 ItemOut  output  3  latched item number, valid while Dispense=1.
REQ-011 Change  output  8  refund amount, valid while ChangeValid=1.
REQ-012 ChangeValid, Short, CoinReject  output  1 each  one-cycle status strobes.

Function
REQ-013 The FSM SHALL use the states IDLE, COLLECT, CHECK, VEND and CHANGE.
REQ-014 In IDLE and COLLECT, a coin pulse SHALL add its value to Credit on that edge, saturating at 255.
REQ-015 Simultaneous coins SHALL credit only the highest-valued one (C25>C10>C5) and pulse CoinReject for one cycle.
REQ-016 Coins in CHECK, VEND or CHANGE SHALL NOT be credited and SHALL pulse CoinReject for one cycle.
REQ-017 IDLE SHALL go to COLLECT on any credited coin.
REQ-018 Buy and Cancel in IDLE SHALL be ignored.
REQ-019 Buy in COLLECT SHALL latch Sel into SelReg and go to CHECK.
REQ-020 A coin arriving with Buy SHALL be credited first.
REQ-021 CHECK SHALL sample Price, which is stable one cycle after SelReg is latched.
REQ-022 CHECK SHALL go to VEND if Price!=0 and Credit>=Price.
REQ-023 Otherwise CHECK SHALL pulse Short for one cycle and return to COLLECT with Credit unchanged.
REQ-024 VEND SHALL assert Dispense for exactly one cycle with ItemOut=SelReg, set Credit to Credit-Price (unsigned, never negative), and go to CHANGE.
REQ-025 CHANGE SHALL assert ChangeValid for one cycle with Change equal to Credit, clear Credit to 0, and go to IDLE.
REQ-026 ChangeValid SHALL be asserted even when the refund is 0.
REQ-027 Cancel in COLLECT SHALL go directly to CHANGE as a full refund.
REQ-028 Cancel together with Buy SHALL give Cancel priority.
REQ-029 Buy and Cancel in CHECK, VEND and CHANGE SHALL be ignored.
REQ-030 Latency SHALL be fixed: Buy sampled at edge n gives Dispense high after edge n+2, then ChangeValid high after edge n+3.
REQ-031 All outputs SHALL be registered.
REQ-032 All strobes SHALL be low outside their specified cycle.

Reset
REQ-033 While Resetn=0 the block SHALL hold state IDLE.
REQ-034 While Resetn=0, Credit, Change, ItemOut and SelReg SHALL be 0.
REQ-035 While Resetn=0, Dispense, ChangeValid, Short and CoinReject SHALL be 0.
REQ-036 Reset asserted in any state, including mid-VEND, SHALL discard credit without producing a Dispense or ChangeValid strobe.
REQ-037 The first edge after reset release SHALL be treated as normal IDLE operation.

Structure
REQ-038 Shared package vend_pkg SHALL hold the state encoding, the coin values (5/10/25), and CREDIT_MAX=255.
REQ-039 Sub-module credit_acc SHALL handle coin priority, saturating add, subtract and clear for Credit.
REQ-040 vend_ctrl SHALL hold the FSM and the output registers.

Verification
REQ-041 Scenario, normal vend: C25, C25, Sel=3, Price=45, Buy -> Dispense with ItemOut=3 two cycles after Buy, then Change=5 with ChangeValid, then Credit=0.
REQ-042 Scenario, insufficient credit: C10, Price=45, Buy -> Short for one cycle, state COLLECT, Credit=10, no Dispense.
REQ-043 Scenario, refund: C25, C10, Cancel -> Change=35 with ChangeValid next cycle, no Dispense.
REQ-044 Scenario, saturation and coin conflicts: eleven C25 -> Credit=255; C5+C25 in one cycle -> +25 only plus CoinReject; coin during VEND -> CoinReject, credit unchanged.
REQ-045 Scenario, control conflicts: Buy+Cancel in one cycle -> refund path taken; Price=0 at CHECK -> Short.
REQ-046 Scenario, reset mid-vend: Resetn low during VEND -> all outputs 0 immediately, no ChangeValid after release.
